// File: rtl/keypad_display_if.sv
// Bundles the scanner-side key inputs and the display-side outputs of the
// keypad display driver so both ends can be wired with a single port.
interface keypad_display_if;
    logic [15:0] buffer;
    logic [3:0]  valid;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        frame_tick;

    modport master (
        output buffer,
        output valid,
        input  an,
        input  seg,
        input  frame_tick
    );

    modport slave (
        input  buffer,
        input  valid,
        output an,
        output seg,
        output frame_tick
    );
endinterface

// File: rtl/keypad_display_driver.sv
// Multiplexes four recorded key codes onto a 4-digit common-anode 7-segment display,
// latching inputs only at frame boundaries and flashing digit 0's dp on a new key.
module keypad_display_driver #(
    parameter logic [15:0] REFRESH_DIV  = 16'd50000,
    parameter logic [3:0]  FLASH_FRAMES = 4'd8
) (
    input  logic             clk,
    input  logic             resetn,
    keypad_display_if.slave  bus
);

    localparam logic [15:0] DIV_LAST = REFRESH_DIV - 16'd1;

    logic [15:0] divCount_q, divCount_d;
    logic [1:0]  digit_q, digit_d;
    logic [15:0] bufLatch_q, bufLatch_d;
    logic [3:0]  validLatch_q, validLatch_d;
    logic [3:0]  flash_q, flash_d;
    logic [3:0]  an_q, an_d;
    logic [7:0]  seg_q, seg_d;
    logic        tick_q, tick_d;

    logic        lastDiv;
    logic        frameEnd;
    logic        inputsChanged;
    logic [7:0]  segHex;

    function automatic logic [7:0] hexSeg(input logic [3:0] nibble);
        logic [7:0] pattern;
        pattern = 8'hFF;
        case (nibble)
            4'h0: pattern = 8'hC0;
            4'h1: pattern = 8'hF9;
            4'h2: pattern = 8'hA4;
            4'h3: pattern = 8'hB0;
            4'h4: pattern = 8'h99;
            4'h5: pattern = 8'h92;
            4'h6: pattern = 8'h82;
            4'h7: pattern = 8'hF8;
            4'h8: pattern = 8'h80;
            4'h9: pattern = 8'h90;
            4'hA: pattern = 8'h88;
            4'hB: pattern = 8'h83;
            4'hC: pattern = 8'hC6;
            4'hD: pattern = 8'hA1;
            4'hE: pattern = 8'h86;
            4'hF: pattern = 8'h8E;
            default: pattern = 8'hFF;
        endcase
        return pattern;
    endfunction

    // Next-state: refresh divider, digit scan, frame-boundary capture, dp flash, output regs.
    always_comb begin
        divCount_d   = divCount_q + 16'd1;
        digit_d      = digit_q;
        bufLatch_d   = bufLatch_q;
        validLatch_d = validLatch_q;
        flash_d      = flash_q;
        tick_d       = 1'b0;

        lastDiv       = (divCount_q == DIV_LAST);
        frameEnd      = lastDiv && (digit_q == 2'd3);
        inputsChanged = (bus.buffer != bufLatch_q) || (bus.valid != validLatch_q);

        if (lastDiv) begin
            divCount_d = 16'd0;
            digit_d    = digit_q + 2'd1;
        end

        // A fresh newest key reloads the flash; otherwise it only ages once per frame.
        if (frameEnd) begin
            bufLatch_d   = bus.buffer;
            validLatch_d = bus.valid;
            tick_d       = 1'b1;
            if (inputsChanged && bus.valid[0]) begin
                flash_d = FLASH_FRAMES;
            end else if (flash_q != 4'd0) begin
                flash_d = flash_q - 4'd1;
            end
        end

        segHex = hexSeg(bufLatch_q[{digit_q, 2'b00} +: 4]);
        an_d   = ~(4'b0001 << digit_q);
        seg_d  = {~((digit_q == 2'd0) && (flash_q != 4'd0) && validLatch_q[0]),
                  validLatch_q[digit_q] ? segHex[6:0] : 7'h7F};
    end

    // State register with synchronous active-low reset; reset leaves the display dark.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            divCount_q   <= 16'd0;
            digit_q      <= 2'd0;
            bufLatch_q   <= 16'd0;
            validLatch_q <= 4'd0;
            flash_q      <= 4'd0;
            an_q         <= 4'hF;
            seg_q        <= 8'hFF;
            tick_q       <= 1'b0;
        end else begin
            divCount_q   <= divCount_d;
            digit_q      <= digit_d;
            bufLatch_q   <= bufLatch_d;
            validLatch_q <= validLatch_d;
            flash_q      <= flash_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            tick_q       <= tick_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.frame_tick = tick_q;

endmodule
